// File: rtl/i2s_fifo_tx.sv
// rtl/i2s_fifo_tx.sv - I2S transmitter draining the audio sample FIFO
// Builds sclk/lrclk from clk; an empty FIFO on a left slot mutes the whole L/R pair.
module i2s_fifo_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_BITS  = 32,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst_a,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  sclk,
  output logic                  lrclk,
  output logic                  sdata,
  output logic                  underrun,
  input  logic                  underrun_clr
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(SLOT_BITS);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX   = BW'(SLOT_BITS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CAPTURE} state_t;

  logic [CW-1:0]         r_cnt;
  logic                  r_sclk;
  logic                  r_lrclk;
  logic                  r_sdata;
  logic [BW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shadow;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_mute_pair;
  logic                  r_underrun;
  state_t                r_state;
  state_t                w_state_nxt;

  logic          w_fall;
  logic [BW-1:0] w_bit_nxt;
  logic          w_slot_start;
  logic          w_load;
  logic          w_shift_bit;
  logic          w_req;
  logic          w_mute_skip;
  logic          w_empty_evt;

  assign w_fall       = enable & r_sclk & (r_cnt == CNT_MAX);
  assign w_bit_nxt    = (r_bit_cnt == BIT_MAX) ? '0 : r_bit_cnt + BW'(1);
  assign w_slot_start = w_fall & (w_bit_nxt == '0);
  assign w_load       = w_fall & (w_bit_nxt == BW'(1));
  assign w_shift_bit  = w_fall & (w_bit_nxt >= BW'(2)) & (w_bit_nxt <= BIT_LAST);

  // A muted pair skips the right-slot fetch so the FIFO stays aligned to left words.
  assign w_req        = enable & (r_state == S_REQ);
  assign w_mute_skip  = r_lrclk & r_mute_pair;
  assign w_empty_evt  = w_req & ~w_mute_skip & fifo_empty;

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      r_cnt     <= '0;
      r_sclk    <= 1'b0;
      r_lrclk   <= 1'b1;
      r_sdata   <= 1'b0;
      r_bit_cnt <= BIT_MAX;
      r_shift   <= '0;
    end else if (!enable) begin
      r_cnt     <= '0;
      r_sclk    <= 1'b0;
      r_lrclk   <= 1'b1;
      r_sdata   <= 1'b0;
      r_bit_cnt <= BIT_MAX;
    end else begin
      if (r_cnt == CNT_MAX) begin
        r_cnt  <= '0;
        r_sclk <= ~r_sclk;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        if (w_bit_nxt == '0)
          r_lrclk <= ~r_lrclk;
        if (w_load) begin
          r_sdata <= r_shadow[DATA_WIDTH-1];
          r_shift <= {r_shadow[DATA_WIDTH-2:0], 1'b0};
        end else if (w_shift_bit) begin
          r_sdata <= r_shift[DATA_WIDTH-1];
          r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
        end else begin
          r_sdata <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a)
      r_state <= S_IDLE;
    else if (!enable)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_slot_start) w_state_nxt = S_REQ;
      S_REQ:     w_state_nxt = (!w_mute_skip && !fifo_empty) ? S_CAPTURE : S_IDLE;
      S_CAPTURE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = 1'b0;
    if (w_req && !w_mute_skip && !fifo_empty)
      fifo_rd_en = 1'b1;
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      r_shadow    <= '0;
      r_mute_pair <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      if (w_empty_evt)
        r_underrun <= 1'b1;
      else if (underrun_clr)
        r_underrun <= 1'b0;

      if (!enable) begin
        r_mute_pair <= 1'b0;
      end else if (w_req) begin
        if (w_mute_skip) begin
          r_shadow    <= '0;
          r_mute_pair <= 1'b0;
        end else if (fifo_empty) begin
          r_shadow <= '0;
          if (!r_lrclk)
            r_mute_pair <= 1'b1;
        end
      end else if (r_state == S_CAPTURE) begin
        r_shadow <= fifo_data;
      end
    end
  end

  assign sclk     = r_sclk;
  assign lrclk    = r_lrclk;
  assign sdata    = r_sdata;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_i2s_fifo_tx.sv
// tb/tb_i2s_fifo_tx.sv - scoreboard bench for i2s_fifo_tx
// A queue-level FIFO/slot model predicts each slot's word; a monitor decodes the I2S stream.
module tb_i2s_fifo_tx;

  localparam int DW       = 16;
  localparam int SB       = 32;
  localparam int CD       = 2;
  localparam int SLOT_CYC = SB * 2 * CD;
  localparam int FRAME    = 2 * SLOT_CYC;
  localparam int NF       = 10;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic enable = 1'b0;
  logic underrun_clr = 1'b0;
  logic [DW-1:0] fifo_data;
  logic fifo_empty, fifo_rd_en, sclk, lrclk, sdata, underrun;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fmem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_count = 0;
  int t_en = 0;

  typedef struct {
    logic          lr;
    logic [DW-1:0] w;
  } slot_t;
  slot_t         expq[$];
  logic [DW-1:0] mq[$];
  int            model_pops = 0;
  logic          m_und = 1'b0;
  logic          m_mute = 1'b0;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  i2s_fifo_tx dut (
    .clk          (clk),
    .rst_a        (rst_a),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_rd_en   (fifo_rd_en),
    .sclk         (sclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  // Behaves like sync_fifo's read port: data appears the cycle after rd_en.
  always @(posedge clk) begin
    t_en <= enable ? t_en + 1 : 0;
    if (fifo_rd_en) begin
      fifo_data <= fmem[rd_ptr % 1024];
      rd_ptr    <= rd_ptr + 1;
      rd_count  <= rd_count + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic        prev_sclk = 1'b0;
  logic        cur_lr = 1'b1;
  int          nbits = 0;
  logic        mdone = 1'b0;
  logic [31:0] pat = '0;
  slot_t       mon_e;

  always @(negedge clk) begin
    if (fifo_rd_en) begin
      chk("rd_en_while_enabled", enable, 1'b1);
      chk("rd_en_not_empty", fifo_empty, 1'b0);
      chk("rd_en_slot_offset", (t_en - 4) % SLOT_CYC, 0);
    end
    if (rst_a || !enable) begin
      nbits     = 0;
      mdone     = 1'b0;
      prev_sclk = 1'b0;
    end else begin
      if (sclk && !prev_sclk) begin
        if ((nbits == 0 && !mdone) || (lrclk !== cur_lr)) begin
          cur_lr = lrclk;
          nbits  = 0;
          mdone  = 1'b0;
          pat    = '0;
        end
        if (!mdone) begin
          pat = {pat[30:0], sdata};
          nbits++;
          if (nbits == SB) begin
            mdone = 1'b1;
            if (expq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL slot_unexpected: got lr=%0d bits=0x%0h expected no slot", cur_lr, pat);
            end else begin
              mon_e = expq.pop_front();
              chk("slot_lr", cur_lr, mon_e.lr);
              chk("slot_bits", pat, {1'b0, mon_e.w, {(SB-DW-1){1'b0}}});
            end
          end
        end
      end
      prev_sclk = sclk;
    end
  end

  task automatic push_word(input logic [DW-1:0] w);
    fmem[wr_ptr % 1024] = w;
    wr_ptr++;
    mq.push_back(w);
  endtask

  task automatic model_left(input bit record);
    slot_t s;
    s.lr = 1'b0;
    s.w  = '0;
    if (mq.size() > 0) begin
      s.w = mq.pop_front();
      model_pops++;
      m_mute = 1'b0;
    end else begin
      m_und  = 1'b1;
      m_mute = 1'b1;
    end
    if (record) expq.push_back(s);
  endtask

  task automatic model_right(input bit record);
    slot_t s;
    s.lr = 1'b1;
    s.w  = '0;
    if (m_mute) begin
      m_mute = 1'b0;
    end else if (mq.size() > 0) begin
      s.w = mq.pop_front();
      model_pops++;
    end else begin
      m_und = 1'b1;
    end
    if (record) expq.push_back(s);
  endtask

  task automatic wait_t(input int target);
    int k;
    k = 0;
    while (t_en < target && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (t_en < target) begin
      checks++;
      errors++;
      $display("FAIL wait_t: reached %0d required %0d", t_en, target);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sclk"}, sclk, 1'b0);
    chk({tag, "_lrclk"}, lrclk, 1'b1);
    chk({tag, "_sdata"}, sdata, 1'b0);
    chk({tag, "_rd_en"}, fifo_rd_en, 1'b0);
  endtask

  initial begin
    int a, b, base, lat;

    #1 rst_a = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset_underrun", underrun, 1'b0);
    rst_a = 1'b0;
    repeat (4) @(negedge clk);
    chk_idle("idle");

    push_word(16'h8001);
    push_word(16'h7FFE);
    model_left(1);
    enable = 1'b1;
    for (int f = 0; f < NF; f++) begin
      base = FRAME * f;
      if (f == 1) begin
        wait_t(base + 4);
        underrun_clr = 1'b1;
        wait_t(base + 5);
        underrun_clr = 1'b0;
        chk("flag_set_wins", underrun, 1'b1);
      end
      wait_t(base + 4 + SLOT_CYC / 2);
      b = (f == 4) ? 1 : ((f < 4) ? 0 : int'($urandom_range(0, 1)));
      for (int i = 0; i < b; i++) push_word(DW'($urandom));
      model_right(1);
      wait_t(base + 4 + SLOT_CYC + SLOT_CYC / 2);
      chk("underrun_sticky", underrun, m_und);
      if (f == 1 || $urandom_range(0, 1) == 1) begin
        underrun_clr = 1'b1;
        wait_t(base + 5 + SLOT_CYC + SLOT_CYC / 2);
        underrun_clr = 1'b0;
        chk("underrun_clr", underrun, 1'b0);
        m_und = 1'b0;
      end
      if (f < NF - 1) begin
        case (f + 1)
          1:       a = 0;
          2:       a = 2;
          3:       a = 1;
          4:       a = 0;
          default: a = int'($urandom_range(0, 2));
        endcase
        for (int i = 0; i < a; i++) push_word((f + 1 == 3) ? 16'h1234 : DW'($urandom));
        model_left(1);
      end
    end
    wait_t(FRAME * (NF - 1) + FRAME + 3);
    enable = 1'b0;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) push_word(DW'($urandom));
    model_left(0);
    enable = 1'b1;
    wait_t(4 + 10 * 2 * CD + 1);
    enable = 1'b0;
    @(negedge clk);
    chk_idle("drop");
    repeat (2) @(negedge clk);
    model_left(1);
    model_right(1);
    enable = 1'b1;
    lat = 0;
    while (lrclk !== 1'b0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("reenable_first_fall", lat, 2 * CD);
    wait_t(FRAME + 3);
    enable = 1'b0;

    repeat (3) @(negedge clk);
    model_left(0);
    enable = 1'b1;
    wait_t(100);
    chk("underrun_before_reset", underrun, m_und);
    #2 rst_a = 1'b1;
    enable = 1'b0;
    #1;
    chk_idle("async_reset");
    chk("async_reset_underrun", underrun, 1'b0);
    @(negedge clk);
    rst_a  = 1'b0;
    m_und  = 1'b0;
    m_mute = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_idle("post_reset");
    end

    chk("slots_drained", expq.size(), 0);
    chk("rd_en_count", rd_count, model_pops);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
